// File: rtl/audio_ctrl_pkg.sv
// Shared types for the WM8731 record/playback controller: FSM state codes,
// speed-mode encoding and the switch decode used to pick the speed mode.
package audio_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_I2C        = 3'd1,
    S_RECD_IDLE  = 3'd2,
    S_RECD       = 3'd3,
    S_RECD_PAUSE = 3'd4,
    S_PLAY_IDLE  = 3'd5,
    S_PLAY       = 3'd6,
    S_PLAY_PAUSE = 3'd7
  } ctrl_state_e;

  typedef enum logic [1:0] {
    SPD_NORMAL = 2'd0,
    SPD_FAST   = 2'd1,
    SPD_SLOW_0 = 2'd2,
    SPD_SLOW_1 = 2'd3
  } speed_mode_e;

  localparam int KEY_STOP  = 0;
  localparam int KEY_START = 1;
  localparam int KEY_DOWN  = 2;

  function automatic speed_mode_e decode_speed(input logic [1:0] sw_speed,
                                               input logic       sw_interp);
    if (!sw_speed[1])     return SPD_NORMAL;
    else if (!sw_speed[0]) return SPD_FAST;
    else if (sw_interp)   return SPD_SLOW_1;
    else                  return SPD_SLOW_0;
  endfunction

endpackage

// File: rtl/audio_ctrl_fsm_key_debounce.sv
// Single-key debouncer: synchronises the raw key, accepts a new level once it
// has been stable for DEB_CYCLES cycles, and emits a one-cycle press pulse.
module key_debounce #(
  parameter int DEB_CYCLES = 1024
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_key,
  output logic o_press
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic             key_p2;
  logic             stable_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_p0  <= 1'b0;
      sync_p1  <= 1'b0;
      key_p2   <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      o_press  <= 1'b0;
    end else begin
      sync_p0 <= i_key;
      sync_p1 <= sync_p0;
      key_p2  <= sync_p1;
      o_press <= 1'b0;
      // Any raw change, or agreement with the accepted level, restarts the count
      if ((sync_p1 != key_p2) || (sync_p1 == stable_q)) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        stable_q <= sync_p1;
        o_press  <= sync_p1;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/audio_ctrl_fsm.sv
// Record/playback controller: key debounce, codec-init/record/play FSM,
// command pulses, per-slot recorded lengths and saturating speed control.
module audio_ctrl_fsm
  import audio_ctrl_pkg::*;
#(
  parameter int ADDR_W     = 20,
  parameter int NUM_SLOTS  = 4,
  parameter int SPEED_W    = 3,
  parameter int MAX_SPEED  = 7,
  parameter int DEB_CYCLES = 1024,
  localparam int SLOT_W    = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [2:0]        i_key,
  input  logic              i_sw_mode,
  input  logic [1:0]        i_sw_speed,
  input  logic              i_sw_interp,
  input  logic              i_i2c_done,
  input  logic [ADDR_W-1:0] i_recd_addr,
  input  logic              i_play_done,
  output logic [2:0]        o_state,
  output logic              o_recd_start,
  output logic              o_recd_pause,
  output logic              o_recd_stop,
  output logic              o_play_start,
  output logic              o_play_pause,
  output logic              o_play_stop,
  output logic [SPEED_W-1:0] o_speed,
  output logic              o_fast,
  output logic              o_slow_0,
  output logic              o_slow_1,
  output logic [SLOT_W-1:0] o_slot,
  output logic [ADDR_W-1:0] o_slot_base,
  output logic [ADDR_W-1:0] o_slot_len,
  output logic              o_sram_we_n
);

  localparam int REG_SH = ADDR_W - $clog2(NUM_SLOTS);
  localparam logic [ADDR_W-1:0]  REG_LAST = ADDR_W'((64'd1 << REG_SH) - 64'd1);
  localparam logic [SPEED_W-1:0] SPD_MAX  = SPEED_W'(MAX_SPEED);

  function automatic logic [SPEED_W-1:0] sat_inc(input logic [SPEED_W-1:0] v);
    return (v >= SPD_MAX) ? SPD_MAX : v + SPEED_W'(1);
  endfunction

  function automatic logic [SPEED_W-1:0] sat_dec(input logic [SPEED_W-1:0] v);
    return (v == '0) ? '0 : v - SPEED_W'(1);
  endfunction

  logic [2:0]         press;
  ctrl_state_e        state_q, state_nxt;
  logic [SLOT_W-1:0]  slot_q, slot_nxt;
  logic [SPEED_W-1:0] fast_q, fast_nxt, slow_q, slow_nxt;
  logic [ADDR_W-1:0]  len_q [NUM_SLOTS];
  logic               len_we;
  logic [ADDR_W-1:0]  len_wdata;
  logic [ADDR_W-1:0]  slot_base;
  logic               slot_full;
  logic               spd_adj;
  speed_mode_e        spd_mode;
  logic               rs_nxt, rp_nxt, rt_nxt, ps_nxt, pp_nxt, pt_nxt;

  for (genvar k = 0; k < 3; k++) begin : g_key
    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_key   (i_key[k]),
      .o_press (press[k])
    );
  end

  assign spd_mode  = decode_speed(i_sw_speed, i_sw_interp);
  assign slot_base = ADDR_W'(slot_q) << REG_SH;
  assign slot_full = (i_recd_addr == (slot_base + REG_LAST));

  always_comb begin
    state_nxt = state_q;
    slot_nxt  = slot_q;
    fast_nxt  = fast_q;
    slow_nxt  = slow_q;
    len_we    = 1'b0;
    len_wdata = i_recd_addr - slot_base;
    spd_adj   = 1'b0;
    rs_nxt = 1'b0; rp_nxt = 1'b0; rt_nxt = 1'b0;
    ps_nxt = 1'b0; pp_nxt = 1'b0; pt_nxt = 1'b0;

    case (state_q)
      S_IDLE: state_nxt = S_I2C;
      S_I2C:  if (i_i2c_done) state_nxt = S_RECD_IDLE;
      S_RECD_IDLE: begin
        if (i_sw_mode) begin
          state_nxt = S_PLAY_IDLE;
        end else if (press[KEY_START]) begin
          state_nxt = S_RECD;
          rs_nxt    = 1'b1;
        end else if (press[KEY_DOWN]) begin
          slot_nxt = (NUM_SLOTS == 1) ? '0 : slot_q + SLOT_W'(1);
        end
      end
      S_RECD: begin
        // A full slot stores the whole region, which the plain difference cannot reach
        if (i_sw_mode || press[KEY_STOP] || slot_full) begin
          state_nxt = i_sw_mode ? S_PLAY_IDLE : S_RECD_IDLE;
          rt_nxt    = 1'b1;
          len_we    = 1'b1;
          if (slot_full) len_wdata = i_recd_addr - slot_base + ADDR_W'(1);
        end else if (press[KEY_START]) begin
          state_nxt = S_RECD_PAUSE;
          rp_nxt    = 1'b1;
        end
      end
      S_RECD_PAUSE: begin
        if (i_sw_mode || press[KEY_STOP]) begin
          state_nxt = i_sw_mode ? S_PLAY_IDLE : S_RECD_IDLE;
          rt_nxt    = 1'b1;
          len_we    = 1'b1;
        end else if (press[KEY_START]) begin
          state_nxt = S_RECD;
          rs_nxt    = 1'b1;
        end
      end
      S_PLAY_IDLE: begin
        if (!i_sw_mode) begin
          state_nxt = S_RECD_IDLE;
        end else begin
          spd_adj = 1'b1;
          if (press[KEY_START] && (len_q[slot_q] != '0)) begin
            state_nxt = S_PLAY;
            ps_nxt    = 1'b1;
          end
        end
      end
      S_PLAY: begin
        if (!i_sw_mode || press[KEY_STOP] || i_play_done) begin
          state_nxt = !i_sw_mode ? S_RECD_IDLE : S_PLAY_IDLE;
          pt_nxt    = 1'b1;
        end else if (press[KEY_START]) begin
          state_nxt = S_PLAY_PAUSE;
          pp_nxt    = 1'b1;
        end
      end
      S_PLAY_PAUSE: begin
        if (!i_sw_mode) begin
          state_nxt = S_RECD_IDLE;
          pt_nxt    = 1'b1;
        end else begin
          spd_adj = 1'b1;
          if (press[KEY_START]) begin
            state_nxt = S_PLAY;
            ps_nxt    = 1'b1;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    // Key0 always means "play faster": raise the fast level or lower the slow one
    if (spd_adj) begin
      case (spd_mode)
        SPD_FAST: begin
          if (press[KEY_STOP] && !press[KEY_DOWN])      fast_nxt = sat_inc(fast_q);
          else if (press[KEY_DOWN] && !press[KEY_STOP]) fast_nxt = sat_dec(fast_q);
        end
        SPD_SLOW_0, SPD_SLOW_1: begin
          if (press[KEY_STOP] && !press[KEY_DOWN])      slow_nxt = sat_dec(slow_q);
          else if (press[KEY_DOWN] && !press[KEY_STOP]) slow_nxt = sat_inc(slow_q);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= S_IDLE;
      slot_q       <= '0;
      fast_q       <= '0;
      slow_q       <= '0;
      o_recd_start <= 1'b0;
      o_recd_pause <= 1'b0;
      o_recd_stop  <= 1'b0;
      o_play_start <= 1'b0;
      o_play_pause <= 1'b0;
      o_play_stop  <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) len_q[i] <= '0;
    end else begin
      state_q      <= state_nxt;
      slot_q       <= slot_nxt;
      fast_q       <= fast_nxt;
      slow_q       <= slow_nxt;
      o_recd_start <= rs_nxt;
      o_recd_pause <= rp_nxt;
      o_recd_stop  <= rt_nxt;
      o_play_start <= ps_nxt;
      o_play_pause <= pp_nxt;
      o_play_stop  <= pt_nxt;
      if (len_we) len_q[slot_q] <= len_wdata;
    end
  end

  always_comb begin
    case (spd_mode)
      SPD_FAST:               o_speed = fast_q;
      SPD_SLOW_0, SPD_SLOW_1: o_speed = slow_q;
      default:                o_speed = '0;
    endcase
  end

  assign o_fast      = (spd_mode == SPD_FAST);
  assign o_slow_0    = (spd_mode == SPD_SLOW_0);
  assign o_slow_1    = (spd_mode == SPD_SLOW_1);
  assign o_state     = state_q;
  assign o_slot      = slot_q;
  assign o_slot_base = slot_base;
  assign o_slot_len  = len_q[slot_q];
  assign o_sram_we_n = (state_q != S_RECD);

endmodule

// File: tb/tb_audio_ctrl_fsm.sv
// Bench for audio_ctrl_fsm: directed key/switch sequences, command pulses
// checked by a queue-based monitor, state/slot/speed checked inline.
module tb_audio_ctrl_fsm;

  localparam int ADDR_W    = 20;
  localparam int NUM_SLOTS = 4;
  localparam int SPEED_W   = 3;
  localparam int MAX_SPEED = 7;
  localparam int DEB       = 16;
  localparam int HOLD      = DEB + 10;

  localparam logic [5:0] P_RS = 6'b100000;
  localparam logic [5:0] P_RP = 6'b010000;
  localparam logic [5:0] P_RT = 6'b001000;
  localparam logic [5:0] P_PS = 6'b000100;
  localparam logic [5:0] P_PP = 6'b000010;
  localparam logic [5:0] P_PT = 6'b000001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] key = 3'b000;
  logic sw_mode = 1'b0;
  logic [1:0] sw_speed = 2'b00;
  logic sw_interp = 1'b0;
  logic i2c_done = 1'b1;
  logic [ADDR_W-1:0] recd_addr = '0;
  logic play_done = 1'b0;

  logic [2:0] state;
  logic recd_start, recd_pause, recd_stop, play_start, play_pause, play_stop;
  logic [SPEED_W-1:0] speed;
  logic fast, slow_0, slow_1;
  logic [1:0] slot;
  logic [ADDR_W-1:0] slot_base, slot_len;
  logic sram_we_n;
  logic [5:0] pulses;

  int total = 0;
  int bad   = 0;
  logic [8:0] exp_q[$];
  logic [8:0] mon_exp;

  audio_ctrl_fsm #(
    .ADDR_W(ADDR_W), .NUM_SLOTS(NUM_SLOTS), .SPEED_W(SPEED_W),
    .MAX_SPEED(MAX_SPEED), .DEB_CYCLES(DEB)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_key(key), .i_sw_mode(sw_mode),
    .i_sw_speed(sw_speed), .i_sw_interp(sw_interp), .i_i2c_done(i2c_done),
    .i_recd_addr(recd_addr), .i_play_done(play_done), .o_state(state),
    .o_recd_start(recd_start), .o_recd_pause(recd_pause), .o_recd_stop(recd_stop),
    .o_play_start(play_start), .o_play_pause(play_pause), .o_play_stop(play_stop),
    .o_speed(speed), .o_fast(fast), .o_slow_0(slow_0), .o_slow_1(slow_1),
    .o_slot(slot), .o_slot_base(slot_base), .o_slot_len(slot_len),
    .o_sram_we_n(sram_we_n)
  );

  assign pulses = {recd_start, recd_pause, recd_stop, play_start, play_pause, play_stop};

  always #5 clk = ~clk;

  // Monitor: every command pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (!rst && (pulses != 6'd0)) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pulse: got pulses=%b state=%0d, want no pulse", pulses, state);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({pulses, state} !== mon_exp) begin
          bad++;
          $display("FAIL pulse_event: got pulses=%b state=%0d, want pulses=%b state=%0d",
                   pulses, state, mon_exp[8:3], mon_exp[2:0]);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic press(input logic [2:0] k);
    key = k;
    tick(HOLD);
    key = 3'b000;
    tick(HOLD);
  endtask

  task automatic expect_evt(input logic [5:0] p, input logic [2:0] st);
    exp_q.push_back({p, st});
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      tick(1);
      n++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s: got %0d pending pulses want 0", nm, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tick(3);
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_pulses", 32'(pulses), 32'd0);
    chk("reset_speed", 32'(speed), 32'd0);
    chk("reset_slot", 32'(slot), 32'd0);
    chk("reset_len", 32'(slot_len), 32'd0);
    chk("reset_we_n", 32'(sram_we_n), 32'd1);
    rst = 1'b0;
    chk("seq_idle", 32'(state), 32'd0);
    tick(1);
    chk("seq_i2c", 32'(state), 32'd1);
    tick(1);
    chk("seq_recd_idle", 32'(state), 32'd2);

    for (int i = 0; i < 6; i++) begin
      key[1] = ~key[1];
      tick(3);
    end
    expect_evt(P_RS, 3'd3);
    press(3'b010);
    drain("bounce_start");
    chk("bounce_state", 32'(state), 32'd3);
    chk("recd_we_n", 32'(sram_we_n), 32'd0);

    recd_addr = 20'h00040;
    expect_evt(P_RT, 3'd2);
    press(3'b001);
    drain("stop_slot0");
    chk("len_slot0", 32'(slot_len), 32'h40);

    press(3'b100);
    press(3'b100);
    chk("slot_sel2", 32'(slot), 32'd2);
    chk("slot_base2", 32'(slot_base), 32'h80000);
    chk("slot_len2_empty", 32'(slot_len), 32'd0);

    expect_evt(P_RS, 3'd3);
    press(3'b010);
    drain("start_slot2");
    recd_addr = 20'h80123;
    expect_evt(P_RT, 3'd2);
    press(3'b001);
    drain("stop_slot2");
    chk("len_slot2", 32'(slot_len), 32'h00123);

    recd_addr = 20'h80010;
    expect_evt(P_RS, 3'd3);
    press(3'b010);
    drain("start_coinc");
    expect_evt(P_RT, 3'd2);
    press(3'b011);
    drain("coinc_stop");
    chk("coinc_state", 32'(state), 32'd2);
    chk("coinc_len", 32'(slot_len), 32'h10);

    expect_evt(P_RS, 3'd3);
    press(3'b010);
    drain("start_full");
    expect_evt(P_RT, 3'd2);
    recd_addr = 20'hBFFFF;
    tick(3);
    drain("slot_full_stop");
    chk("slot_full_len", 32'(slot_len), 32'h40000);
    chk("slot_full_state", 32'(state), 32'd2);

    press(3'b100);
    press(3'b100);
    chk("slot_wrap", 32'(slot), 32'd0);
    chk("slot_wrap_len", 32'(slot_len), 32'h40);

    sw_mode = 1'b1;
    tick(2);
    chk("to_play_idle", 32'(state), 32'd5);

    sw_speed = 2'b10;
    tick(1);
    chk("fast_flags", 32'({fast, slow_0, slow_1}), 32'b100);
    press(3'b001);
    chk("fast_inc1", 32'(speed), 32'd1);
    for (int i = 0; i < 8; i++) press(3'b001);
    chk("fast_sat_hi", 32'(speed), 32'd7);
    for (int i = 0; i < 9; i++) press(3'b100);
    chk("fast_sat_lo", 32'(speed), 32'd0);

    sw_speed = 2'b11;
    sw_interp = 1'b1;
    tick(1);
    chk("slow1_flags", 32'({fast, slow_0, slow_1}), 32'b001);
    press(3'b100);
    chk("slow_down", 32'(speed), 32'd1);
    press(3'b001);
    press(3'b001);
    chk("slow_sat_lo", 32'(speed), 32'd0);

    sw_speed = 2'b00;
    press(3'b001);
    chk("normal_speed", 32'(speed), 32'd0);
    chk("normal_flags", 32'({fast, slow_0, slow_1}), 32'b000);
    press(3'b100);
    chk("no_slot_in_play", 32'(slot), 32'd0);
    sw_speed = 2'b10;
    tick(1);
    chk("fast_kept", 32'(speed), 32'd0);
    sw_speed = 2'b00;

    expect_evt(P_PS, 3'd6);
    press(3'b010);
    drain("play_start");
    expect_evt(P_PP, 3'd7);
    press(3'b010);
    drain("play_pause");
    expect_evt(P_PS, 3'd6);
    press(3'b010);
    drain("play_resume");
    expect_evt(P_PT, 3'd5);
    play_done = 1'b1;
    tick(1);
    play_done = 1'b0;
    drain("play_done_stop");
    chk("play_done_state", 32'(state), 32'd5);

    sw_mode = 1'b0;
    tick(2);
    chk("back_recd_idle", 32'(state), 32'd2);
    press(3'b100);
    chk("slot1", 32'(slot), 32'd1);
    sw_mode = 1'b1;
    tick(2);
    press(3'b010);
    chk("empty_slot_play", 32'(state), 32'd5);
    play_done = 1'b1;
    tick(1);
    play_done = 1'b0;
    tick(3);
    chk("play_done_ignored", 32'(state), 32'd5);

    sw_mode = 1'b0;
    tick(2);
    press(3'b100);
    press(3'b100);
    press(3'b100);
    chk("slot0_again", 32'(slot), 32'd0);
    sw_mode = 1'b1;
    tick(2);
    expect_evt(P_PS, 3'd6);
    press(3'b010);
    drain("play_start2");
    expect_evt(P_PT, 3'd2);
    sw_mode = 1'b0;
    tick(3);
    drain("mode_flip_play");
    chk("mode_flip_play_state", 32'(state), 32'd2);

    recd_addr = 20'h00000;
    expect_evt(P_RS, 3'd3);
    press(3'b010);
    drain("start_flip_recd");
    recd_addr = 20'h00020;
    expect_evt(P_RT, 3'd5);
    sw_mode = 1'b1;
    tick(3);
    drain("mode_flip_recd");
    chk("mode_flip_recd_len", 32'(slot_len), 32'h20);
    chk("mode_flip_recd_state", 32'(state), 32'd5);

    rst = 1'b1;
    tick(2);
    chk("rst_mid_state", 32'(state), 32'd0);
    chk("rst_mid_len", 32'(slot_len), 32'd0);
    rst = 1'b0;
    tick(HOLD);
    chk("no_pending", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
